// File: rtl/bsg_link_core_rx_gearbox.sv
// Downstream-to-core gearbox: pops IN_WIDTH-bit words (valid/yumi) and emits OUT_WIDTH-bit beats,
// low slice first, over valid/ready. Optional statistics counters guarded by `LINK_RX_STATS_EN.
module bsg_link_core_rx_gearbox #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 core_clk_i,
   input  logic                 core_reset_n_i,
   input  logic                 link_valid_i,
   input  logic [IN_WIDTH-1:0]  link_data_i,
   output logic                 link_yumi_o,
   output logic                 out_valid_o,
   output logic [OUT_WIDTH-1:0] out_data_o,
   output logic                 out_last_o,
   input  logic                 out_ready_i,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] stat_words_o,
   output logic [CNT_WIDTH-1:0] stat_beats_o,
   output logic [CNT_WIDTH-1:0] stat_stall_o
);

   localparam int BEATS = IN_WIDTH / OUT_WIDTH;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   // State encoding is literally {active_v, next_v}.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } state_e;

   state_e                             state_q;
   logic [IDX_W-1:0]                   idx_q;
   logic [IDX_W-1:0]                   idx_d;
   logic [BEATS-1:0][OUT_WIDTH-1:0]    active_q;
   logic [IN_WIDTH-1:0]                next_q;

   logic active_v;
   logic next_v;
   logic yumi;
   logic fire;
   logic last;
   logic retire;

   assign active_v = state_q[1];
   assign next_v   = state_q[0];
   assign yumi     = core_reset_n_i & link_valid_i & ~next_v;
   assign fire     = active_v & out_ready_i;
   assign last     = (idx_q == IDX_W'(BEATS - 1));
   assign retire   = fire & last;

   always_comb begin
      idx_d = idx_q;
      if (retire)    idx_d = '0;
      else if (fire) idx_d = idx_q + IDX_W'(1);
   end

   always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         state_q  <= EMPTY;
         idx_q    <= '0;
         active_q <= '0;
         next_q   <= '0;
      end else begin
         idx_q <= idx_d;
         case (state_q)
            EMPTY: begin
               if (yumi) begin
                  active_q <= link_data_i;
                  idx_q    <= '0;
                  state_q  <= ONE;
               end
            end
            ONE: begin
               // A word arriving in the same cycle the active word retires bypasses next.
               if (yumi && !retire) begin
                  next_q  <= link_data_i;
                  state_q <= TWO;
               end else if (yumi) begin
                  active_q <= link_data_i;
               end else if (retire) begin
                  state_q <= EMPTY;
               end
            end
            TWO: begin
               if (retire) begin
                  active_q <= next_q;
                  state_q  <= ONE;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign link_yumi_o = yumi;
   assign out_valid_o = active_v;
   assign out_data_o  = active_q[idx_q];
   assign out_last_o  = active_v & last;
   assign busy_o      = (state_q != EMPTY);

`ifdef LINK_RX_STATS_EN
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic                 en);
      return (en && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;
   endfunction

   logic [CNT_WIDTH-1:0] words_q;
   logic [CNT_WIDTH-1:0] beats_q;
   logic [CNT_WIDTH-1:0] stall_q;

   always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         words_q <= '0;
         beats_q <= '0;
         stall_q <= '0;
      end else begin
         words_q <= sat_inc(words_q, yumi);
         beats_q <= sat_inc(beats_q, fire);
         stall_q <= sat_inc(stall_q, active_v & ~out_ready_i);
      end
   end

   assign stat_words_o = words_q;
   assign stat_beats_o = beats_q;
   assign stat_stall_o = stall_q;
`else
   assign stat_words_o = '0;
   assign stat_beats_o = '0;
   assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_bsg_link_core_rx_gearbox.sv
// Scoreboard bench for bsg_link_core_rx_gearbox: a beat-queue reference model predicts
// yumi, beat order, last flags, busy and statistics.
module tb_bsg_link_core_rx_gearbox;

   localparam int IW    = 64;
   localparam int OW    = 16;
   localparam int CW    = 6;
   localparam int BEATS = IW / OW;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          lv;
   logic [IW-1:0] ld;
   logic          yumi;
   logic          ov;
   logic [OW-1:0] od;
   logic          ol;
   logic          rdy;
   logic          busy;
   logic [CW-1:0] sw, sb, ss;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [OW-1:0] d;
      logic          l;
   } beat_t;

   beat_t q[$];
   int    m_words = 0;
   int    m_beats = 0;
   int    m_stall = 0;

   always #5 clk = ~clk;

   bsg_link_core_rx_gearbox #(
      .IN_WIDTH (IW),
      .OUT_WIDTH(OW),
      .CNT_WIDTH(CW)
   ) dut (
      .core_clk_i    (clk),
      .core_reset_n_i(rst_n),
      .link_valid_i  (lv),
      .link_data_i   (ld),
      .link_yumi_o   (yumi),
      .out_valid_o   (ov),
      .out_data_o    (od),
      .out_last_o    (ol),
      .out_ready_i   (rdy),
      .busy_o        (busy),
      .stat_words_o  (sw),
      .stat_beats_o  (sb),
      .stat_stall_o  (ss)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic logic [63:0] exp_stat(input int v);
`ifdef LINK_RX_STATS_EN
      return 64'(v);
`else
      return 64'(v * 0);
`endif
   endfunction

   // Monitor: inputs are stable from posedge+1 to the next posedge, so the negedge
   // sees exactly what the coming edge will act on.
   always @(negedge clk) begin
      int   held;
      logic eyumi;
      if (!rst_n) begin
         check("rst_valid", ov, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_yumi", yumi, 1'b0);
         check("rst_data", od, '0);
         check("rst_last", ol, 1'b0);
         check("rst_stat_words", sw, '0);
         q.delete();
         m_words = 0;
         m_beats = 0;
         m_stall = 0;
      end else begin
         held  = (q.size() + BEATS - 1) / BEATS;
         eyumi = lv && (held < 2);
         check("yumi", yumi, eyumi);
         check("valid", ov, q.size() != 0);
         check("busy", busy, q.size() != 0);
         check("stat_words", sw, exp_stat(m_words));
         check("stat_beats", sb, exp_stat(m_beats));
         check("stat_stall", ss, exp_stat(m_stall));
         if (q.size() != 0) begin
            check("beat_data", od, q[0].d);
            check("beat_last", ol, q[0].l);
            if (rdy) begin
               void'(q.pop_front());
               m_beats = sat(m_beats + 1);
            end else begin
               m_stall = sat(m_stall + 1);
            end
         end else begin
            check("idle_last", ol, 1'b0);
         end
         if (eyumi) begin
            for (int i = 0; i < BEATS; i++) begin
               beat_t b;
               b.d = ld[i*OW +: OW];
               b.l = (i == BEATS - 1);
               q.push_back(b);
            end
            m_words = sat(m_words + 1);
         end
      end
   end

   function automatic logic [IW-1:0] rand_word();
      return {$urandom, $urandom};
   endfunction

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      lv    = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      lv    = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      lv  = 1'b0;
      rdy = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 100);
      check("drain_idle", busy, 1'b0);
   endtask

   task automatic stream(input int nwords, input int vpct, input int rpct);
      int   cnt;
      int   guard;
      logic took;
      cnt   = 0;
      guard = 0;
      ld    = rand_word();
      lv    = ($urandom_range(99) < vpct);
      rdy   = ($urandom_range(99) < rpct);
      while (cnt < nwords && guard < 5000) begin
         @(negedge clk);
         took = yumi & lv;
         @(posedge clk); #1;
         guard++;
         if (took) begin
            cnt++;
            ld = rand_word();
         end
         lv  = (cnt < nwords) && ($urandom_range(99) < vpct);
         rdy = ($urandom_range(99) < rpct);
      end
      lv = 1'b0;
      check("stream_timeout", guard < 5000, 1'b1);
   endtask

   initial begin
      // T1: reset held with valid asserted
      rst_n = 1'b0;
      lv    = 1'b1;
      ld    = 64'hDEAD_BEEF_DEAD_BEEF;
      rdy   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      lv    = 1'b0;

      // T2: single word, ready held high
      @(posedge clk); #1;
      lv = 1'b1;
      ld = 64'h0123_4567_89AB_CDEF;
      @(posedge clk); #1;
      lv = 1'b0;
      @(negedge clk);
      check("t2_first_beat", od, 16'hCDEF);
      repeat (4) @(negedge clk);
      check("t2_busy_after", busy, 1'b0);

      // T3: eight words streamed back to back
      stream(8, 100, 100);
      drain();

      // T4/T6: two words under backpressure, then exactly three stall cycles
      pulse_reset();
      @(posedge clk); #1;
      lv  = 1'b1;
      rdy = 1'b0;
      ld  = 64'h1111_2222_3333_4444;
      @(posedge clk); #1;
      ld  = 64'h5555_6666_7777_8888;
      @(posedge clk); #1;
      ld  = 64'h9999_AAAA_BBBB_CCCC;
      @(negedge clk);
      check("t4_yumi_full", yumi, 1'b0);
      check("t4_beat0_held", od, 16'h4444);
      @(posedge clk); #1;
      lv = 1'b0;
      @(negedge clk);
      check("t4_beat0_stable", od, 16'h4444);
      @(posedge clk); #1;
      rdy = 1'b1;
      drain();
      check("t6_words", sw, exp_stat(2));
      check("t6_beats", sb, exp_stat(8));
      check("t6_stall", ss, exp_stat(3));

      // T5: reset after two beats of a word, next word must restart at slice 0
      @(posedge clk); #1;
      lv  = 1'b1;
      rdy = 1'b1;
      ld  = 64'hAAAA_BBBB_CCCC_DDDD;
      @(posedge clk); #1;
      lv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_rst_valid", ov, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lv = 1'b1;
      ld = 64'h0F0E_0D0C_0B0A_0908;
      @(posedge clk); #1;
      lv = 1'b0;
      @(negedge clk);
      check("t5_slice0", od, 16'h0908);
      drain();

      // Random traffic; beat count overruns the narrow counters to exercise saturation
      pulse_reset();
      stream(40, 70, 60);
      drain();
      stream(20, 100, 30);
      drain();
      check("final_stat_beats", sb, exp_stat(CMAX));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
